// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the memory-port arbitration logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_mem_pkg;

  // Default refill burst length in words
  localparam int DEFAULT_BLOCK_WORDS = 4;
  localparam int BEAT_W = $clog2(DEFAULT_BLOCK_WORDS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_BURST = 2'd1,
    D_XFER  = 2'd2
  } mem_arb_state_t;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } mem_grant_t;

endpackage

// File: rtl/mem_rr_select.sv
// Two-way round-robin pick between instruction refill and data requests.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module mem_rr_select
  import riscv_mem_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  mem_grant_t last_grant,
  output logic       grant_vld,
  output mem_grant_t grant_side
);

  // A lone requester wins outright; on a tie the side not served last wins
  always_comb begin
    grant_vld  = i_req | d_req;
    grant_side = INSTR;
    if (i_req && d_req) begin
      grant_side = (last_grant == INSTR) ? DATA : INSTR;
    end else if (d_req) begin
      grant_side = DATA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the main-memory port between I-cache refill bursts and single data accesses.
// Latency: request seen in IDLE -> MemReq next cycle; one IDLE cycle after every completion.
// Backpressure: MemReq and its fields hold until MemAck; grant held for a whole transaction.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int  WIDTH       = 32,
  parameter int  BLOCK_WORDS = DEFAULT_BLOCK_WORDS,
  localparam int BEAT_WIDTH  = $clog2(BLOCK_WORDS)
) (
  input  logic                  clk,
  input  logic                  reset,
  // instruction refill side
  input  logic                  IReq,
  input  logic [WIDTH-1:0]      IAddr,
  output logic                  IRdValid,
  output logic [WIDTH-1:0]      IRdData,
  output logic [BEAT_WIDTH-1:0] IBeat,
  output logic                  IDone,
  // data side
  input  logic                  DReq,
  input  logic                  DWe,
  input  logic [WIDTH-1:0]      DAddr,
  input  logic [WIDTH-1:0]      DWData,
  input  logic [3:0]            DBe,
  output logic [WIDTH-1:0]      DRdData,
  output logic                  DDone,
  // memory side
  output logic                  MemReq,
  output logic                  MemWe,
  output logic [WIDTH-1:0]      MemAddr,
  output logic [WIDTH-1:0]      MemWData,
  output logic [3:0]            MemBe,
  input  logic                  MemAck,
  input  logic [WIDTH-1:0]      MemRdData
);

  localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(BLOCK_WORDS - 1);

  mem_arb_state_t        state_q, state_d;
  mem_grant_t            last_grant_q, last_grant_d;
  logic [BEAT_WIDTH-1:0] beat_q, beat_d;

  logic       grant_vld;
  mem_grant_t grant_side;

  // Refill bursts are block aligned, so the in-block offset of IAddr is never used
  logic unused_iaddr_lo;
  assign unused_iaddr_lo = ^IAddr[BEAT_WIDTH+1:0];

  // Read data fans out to both requesters; the valid/done strobes qualify it
  assign IRdData = MemRdData;
  assign DRdData = MemRdData;

  mem_rr_select u_rr_select (
    .i_req      (IReq),
    .d_req      (DReq),
    .last_grant (last_grant_q),
    .grant_vld  (grant_vld),
    .grant_side (grant_side)
  );

  // Next-state, beat counter and memory-port muxing; everything is forced quiet under reset
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    beat_d       = beat_q;
    MemReq       = 1'b0;
    MemWe        = 1'b0;
    MemAddr      = '0;
    MemWData     = '0;
    MemBe        = 4'h0;
    IRdValid     = 1'b0;
    IBeat        = '0;
    IDone        = 1'b0;
    DDone        = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            state_d      = (grant_side == INSTR) ? I_BURST : D_XFER;
            last_grant_d = grant_side;
            beat_d       = '0;
          end
        end
        I_BURST: begin
          MemReq  = 1'b1;
          MemBe   = 4'hF;
          MemAddr = {IAddr[WIDTH-1:BEAT_WIDTH+2], beat_q, 2'b00};
          IBeat   = beat_q;
          if (MemAck) begin
            IRdValid = 1'b1;
            if (beat_q == LAST_BEAT) begin
              IDone   = 1'b1;
              beat_d  = '0;
              state_d = IDLE;
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end
        end
        D_XFER: begin
          MemReq   = 1'b1;
          MemWe    = DWe;
          MemAddr  = DAddr;
          MemWData = DWData;
          MemBe    = DBe;
          if (MemAck) begin
            DDone   = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, last-grant and beat registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= INSTR;
      beat_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      beat_q       <= beat_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized rounds
// checked against a transaction-level model (grant order, address lists, timing).
// A memory responder with programmable ack wait drives the memory side.
module tb_mem_port_arbiter;
  import riscv_mem_pkg::*;

  localparam int W  = 32;
  localparam int BW = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              IReq;
  logic [W-1:0]      IAddr;
  logic              IRdValid;
  logic [W-1:0]      IRdData;
  logic [BEAT_W-1:0] IBeat;
  logic              IDone;
  logic              DReq;
  logic              DWe;
  logic [W-1:0]      DAddr;
  logic [W-1:0]      DWData;
  logic [3:0]        DBe;
  logic [W-1:0]      DRdData;
  logic              DDone;
  logic              MemReq;
  logic              MemWe;
  logic [W-1:0]      MemAddr;
  logic [W-1:0]      MemWData;
  logic [3:0]        MemBe;
  logic              MemAck;
  logic [W-1:0]      MemRdData;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WIDTH(W), .BLOCK_WORDS(BW)) dut (
    .clk(clk), .reset(reset),
    .IReq(IReq), .IAddr(IAddr), .IRdValid(IRdValid), .IRdData(IRdData),
    .IBeat(IBeat), .IDone(IDone),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData), .DBe(DBe),
    .DRdData(DRdData), .DDone(DDone),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemBe(MemBe), .MemAck(MemAck), .MemRdData(MemRdData)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Memory contents are a pure function of the address
  function automatic logic [31:0] rd_value(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mtx_t;

  // Observation logs filled by the monitor
  mtx_t        mem_log[$];
  logic [31:0] i_data_log[$];
  int          i_beat_log[$];
  int          start_log[$];
  int          done_log[$];
  int          idone_cnt;
  int          ddone_cnt;
  logic [31:0] d_rdata;

  // Model: which side the arbiter served last (0 = instruction, 1 = data)
  bit m_last_data = 1'b0;

  // Responder controls
  int ack_wait  = 0;
  bit force_ack = 1'b0;
  int wait_cnt  = 0;

  task automatic clear_logs();
    mem_log.delete(); i_data_log.delete(); i_beat_log.delete();
    start_log.delete(); done_log.delete();
    idone_cnt = 0; ddone_cnt = 0; d_rdata = '0;
  endtask

  initial begin : cycle_counter
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Memory model: acks each pending beat after ack_wait idle cycles
  initial begin : responder
    MemAck = 1'b0;
    MemRdData = '0;
    forever begin
      @(posedge clk); #1;
      if (force_ack) begin
        MemAck = 1'b1;
        MemRdData = 32'hBAD0_0000 | 32'($urandom_range(0, 65535));
      end else if (MemReq) begin
        if (wait_cnt >= ack_wait) begin
          MemAck = 1'b1;
          MemRdData = rd_value(MemAddr);
          wait_cnt = 0;
        end else begin
          MemAck = 1'b0;
          wait_cnt++;
        end
      end else begin
        MemAck = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Monitor: logs completed beats/transactions and checks request hold
  initial begin : monitor
    bit          pend;
    bit          prev_busy;
    logic [69:0] pend_vec;
    pend = 1'b0; prev_busy = 1'b0; pend_vec = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend = 1'b0;
        prev_busy = 1'b0;
      end else begin
        if (pend) check("mem_hold", {MemReq, MemWe, MemAddr, MemWData, MemBe}, pend_vec);
        if (MemReq && !prev_busy) start_log.push_back(cyc);
        if (MemReq && MemAck) mem_log.push_back('{we: MemWe, addr: MemAddr, wdata: MemWData, be: MemBe});
        if (IRdValid) begin
          i_data_log.push_back(IRdData);
          i_beat_log.push_back(int'(IBeat));
        end
        if (IDone) begin idone_cnt++; done_log.push_back(cyc); end
        if (DDone) begin ddone_cnt++; done_log.push_back(cyc); d_rdata = DRdData; end
        pend = MemReq && !MemAck;
        pend_vec = {MemReq, MemWe, MemAddr, MemWData, MemBe};
        prev_busy = MemReq && !(IDone || DDone);
      end
    end
  end

  task automatic reset_dut();
    @(posedge clk); #1;
    reset = 1'b1; IReq = 1'b0; DReq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_last_data = 1'b0;
  endtask

  // One round: raise the chosen requests, hold until each Done, compare with the model
  task automatic run_round(input bit do_i, input bit do_d, input int w, input bit i_drop,
                           input logic [31:0] ia, input logic [31:0] da,
                           input logic [31:0] dwd, input logic dwe, input logic [3:0] dbe);
    mtx_t        exp_q[$];
    bit          exp_d[$];
    bit          order[$];
    logic [31:0] ibase;
    int          req_cyc;
    int          dur;
    bit          got_i, got_d;
    clear_logs();
    ack_wait = w;
    ibase = {ia[31:4], 4'b0000};
    if (do_i && do_d) order = m_last_data ? '{1'b0, 1'b1} : '{1'b1, 1'b0};
    else if (do_i)    order = '{1'b0};
    else              order = '{1'b1};
    m_last_data = order[order.size()-1];
    foreach (order[k]) begin
      if (!order[k]) begin
        for (int b = 0; b < BW; b++) begin
          exp_q.push_back('{we: 1'b0, addr: ibase + 32'(4*b), wdata: 32'h0, be: 4'hF});
          exp_d.push_back(1'b0);
        end
      end else begin
        exp_q.push_back('{we: dwe, addr: da, wdata: dwd, be: dbe});
        exp_d.push_back(1'b1);
      end
    end

    @(posedge clk); #1;
    IAddr = ia; DAddr = da; DWData = dwd; DWe = dwe; DBe = dbe;
    IReq = do_i; DReq = do_d;
    req_cyc = cyc;
    got_i = !do_i; got_d = !do_d;
    for (int c = 0; c < 400 && !(got_i && got_d); c++) begin
      @(negedge clk);
      if (IDone) got_i = 1'b1;
      if (DDone) got_d = 1'b1;
      @(posedge clk); #1;
      if (got_i || (i_drop && i_beat_log.size() > 0)) IReq = 1'b0;
      if (got_d) DReq = 1'b0;
    end
    check("round_timeout", got_i && got_d, 1'b1);

    check("n_mem", mem_log.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < mem_log.size(); k++) begin
      check("mem_we",   mem_log[k].we,   exp_q[k].we);
      check("mem_addr", mem_log[k].addr, exp_q[k].addr);
      check("mem_be",   mem_log[k].be,   exp_q[k].be);
      if (exp_d[k]) check("mem_wdata", mem_log[k].wdata, exp_q[k].wdata);
    end
    check("idone_cnt", idone_cnt, do_i);
    check("ddone_cnt", ddone_cnt, do_d);
    if (do_i) begin
      check("n_ibeats", i_beat_log.size(), BW);
      for (int k = 0; k < i_beat_log.size() && k < BW; k++) begin
        check("ibeat",  i_beat_log[k], k);
        check("irdata", i_data_log[k], rd_value(ibase + 32'(4*k)));
      end
    end
    if (do_d && !dwe) check("drdata", d_rdata, rd_value(da));

    check("n_starts", start_log.size(), order.size());
    if (start_log.size() > 0) check("first_latency", start_log[0], req_cyc + 1);
    if (start_log.size() >= order.size() && done_log.size() >= order.size()) begin
      foreach (order[k]) begin
        dur = (order[k] ? 1 : BW) * (w + 1) - 1;
        check("xfer_len", done_log[k] - start_log[k], dur);
        if (k > 0) check("idle_gap", start_log[k], done_log[k-1] + 2);
      end
    end
  endtask

  initial begin : main
    bit found;
    int sel;
    reset = 1'b1;
    IReq = 1'b0; IAddr = '0;
    DReq = 1'b0; DWe = 1'b0; DAddr = '0; DWData = '0; DBe = 4'h0;
    clear_logs();

    // Outputs during reset and in IDLE
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_memreq", MemReq, 1'b0);
    check("rst_done", {IRdValid, IDone, DDone, MemWe}, 4'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_memreq", MemReq, 1'b0);
    check("idle_ibeat", IBeat, '0);
    check("idle_membe", MemBe, 4'h0);
    check("idle_memaddr", MemAddr, 32'h0);
    check("idle_memwdata", MemWData, 32'h0);

    // I-only refill, ack every cycle
    run_round(1'b1, 1'b0, 0, 1'b0, 32'h0000_1234, 32'h0, 32'h0, 1'b0, 4'h0);
    // D write, ack after 3 wait cycles
    run_round(1'b0, 1'b1, 3, 1'b0, 32'h0, 32'h2000_0008, 32'hDEAD_BEEF, 1'b1, 4'b0011);

    // Ties after reset: data first, then alternation under sustained contention
    reset_dut();
    for (int r = 0; r < 4; r++) begin
      run_round(1'b1, 1'b1, r % 2, 1'b0, 32'h0000_4000 + 32'(r*16), 32'h3000_0000 + 32'(r*4),
                32'h1111_0000 + 32'(r), r[0], 4'hF);
    end

    // Reset while beat 2 of a burst is outstanding
    clear_logs();
    ack_wait = 0;
    @(posedge clk); #1;
    IAddr = 32'h0000_5678; IReq = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (IRdValid && IBeat == 2'd1) found = 1'b1;
    end
    check("beat1_seen", found, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1; IReq = 1'b0;
    @(negedge clk);
    check("midrst_memreq", MemReq, 1'b0);
    check("midrst_irdvalid", IRdValid, 1'b0);
    check("midrst_idone", IDone, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0; m_last_data = 1'b0;
    @(negedge clk);
    check("postrst_memreq", MemReq, 1'b0);
    repeat (3) @(negedge clk);
    check("postrst_no_idone", idone_cnt, 0);
    run_round(1'b1, 1'b0, 1, 1'b0, 32'h0000_5678, 32'h0, 32'h0, 1'b0, 4'h0);

    // Spurious acks while idle are ignored
    @(posedge clk); #1;
    force_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("spur_strobes", {IRdValid, IDone, DDone, MemReq}, 4'h0);
      @(posedge clk); #1;
    end
    force_ack = 1'b0;
    // IReq dropped after the first beat: burst still completes
    run_round(1'b1, 1'b0, 1, 1'b1, 32'h0000_ABCC, 32'h0, 32'h0, 1'b0, 4'h0);

    // Randomized rounds
    for (int r = 0; r < 25; r++) begin
      sel = $urandom_range(1, 3);
      run_round(sel[0], sel[1], $urandom_range(0, 2), 1'b0, $urandom, $urandom, $urandom,
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single main-memory port between the instruction-cache refill path and the data-memory path of pipelined_riscv_core's memory subsystem.
- Instruction side issues aligned read bursts of BLOCK_WORDS words on a cache miss; data side issues single-word reads/writes.
- Grant is held for a whole transaction. Ties between requesters are resolved round-robin.
- Sits between the caches/LSU and the external memory model.

Parameters:
- WIDTH, 32, data and address width
- BLOCK_WORDS, 4, words per instruction refill burst (power of 2, ≥2)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- IReq  input  1  instruction refill request; held until IDone
- IAddr  input  WIDTH  refill address; low log2(BLOCK_WORDS)+2 bits ignored
- IRdValid  output  1  refill beat valid
- IRdData  output  WIDTH  refill beat data
- IBeat  output  log2(BLOCK_WORDS)  index of current refill beat
- IDone  output  1  one-cycle pulse on last refill beat
- DReq  input  1  data request; held until DDone
- DWe  input  1  1 = write, 0 = read
- DAddr  input  WIDTH  word address (low 2 bits passed through)
- DWData  input  WIDTH  write data
- DBe  input  4  byte enables
- DRdData  output  WIDTH  read data, valid with DDone
- DDone  output  1  one-cycle completion pulse
- MemReq  output  1  memory request; held until MemAck
- MemWe  output  1  memory write enable
- MemAddr  output  WIDTH  memory address
- MemWData  output  WIDTH  memory write data
- MemBe  output  4  memory byte enables
- MemAck  input  1  beat accepted/completed; read data valid same cycle
- MemRdData  input  WIDTH  memory read data

Behaviour:
- Clocking and reset are fixed: one clock, clk; reset is synchronous and active-high.
- Reset state: FSM in IDLE, LastGrant=INSTR, beat counter 0.
- Outputs during reset and in IDLE: MemReq, MemWe, IRdValid, IDone and DDone are 0. IBeat=0, MemBe=0, MemAddr=0 and MemWData=0.
- FSM states: IDLE, I_BURST, D_XFER.
- Transitions from IDLE (decided from registered state and current requests):
  - IReq only → I_BURST
  - DReq only → D_XFER
  - both → the side not equal to LastGrant
  - LastGrant updates on entry to a grant state.
- Latency: a request sampled in IDLE at cycle n gives MemReq=1 at cycle n+1. MemReq is decoded from state, not from IReq/DReq.
- I_BURST:
  - MemWe=0, MemBe=4'hF.
  - MemAddr = {IAddr[WIDTH-1:log2(BLOCK_WORDS)+2], beat, 2'b00}.
  - On MemAck: IRdValid=1, IRdData=MemRdData, IBeat=beat, then beat increments.
  - On the ack of beat BLOCK_WORDS-1: IDone=1 in the same cycle, beat clears, next state IDLE.
- D_XFER:
  - MemWe=DWe, MemAddr=DAddr, MemWData=DWData, MemBe=DBe.
  - On MemAck: DDone=1 and DRdData=MemRdData (DRdData is don't-care for writes), next state IDLE.
- MemReq stays high, with stable address and data, until MemAck. Consecutive burst beats carry no bubble: MemReq stays 1 between beats.
- One mandatory IDLE cycle follows every completion. The earliest next grant comes 2 cycles after Done.
- Requests dropped mid-transaction are ignored: the transaction completes. Requesters must hold their Req, address and data stable until Done.
- MemAck outside a grant state is ignored.
- Reset mid-transaction: abandons immediately to IDLE with all outputs cleared. No Done pulse is generated.
- Starvation bound: a continuously asserted request is granted within one competing transaction.

Decomposition:
- Shared package riscv_mem_pkg holds:
  - mem_arb_state_t enum (IDLE, I_BURST, D_XFER)
  - mem_grant_t enum (INSTR, DATA)
  - BLOCK_WORDS default constant
  - BEAT_W = $clog2(BLOCK_WORDS)
- One sub-module, mem_rr_select: a combinational two-way round-robin pick from IReq, DReq and LastGrant, returning grant valid and side.
- FSM, beat counter and output muxing stay in mem_port_arbiter.

Test Plan:
- I-only refill: IReq=1, IAddr=32'h0000_1234, MemAck every cycle → MemAddr sequence 0x1230, 0x1234, 0x1238, 0x123C. IRdValid on 4 consecutive cycles with IBeat 0–3. IDone coincides with the 4th beat. First MemReq comes 1 cycle after IReq.
- D write: DReq=1, DWe=1, DAddr=0x2000_0008, DWData=0xDEADBEEF, DBe=4'b0011, MemAck after 3 wait cycles → MemReq and all fields stable for 4 cycles. DDone pulses exactly once, on the ack cycle.
- Simultaneous requests after reset: IReq=DReq=1 → data side is granted first (LastGrant=INSTR). After DDone plus one IDLE cycle, I_BURST is granted. A second tie after that burst grants DATA again.
- Sustained contention: both requests held for 6 transactions → grants alternate D, I, D, I, D, I with no starvation.
- Reset at I_BURST beat 2 → next cycle MemReq=0, IRdValid=0, IDone never pulses. A fresh IReq restarts at beat 0 with address 0x…0.
- Spurious MemAck in IDLE, and IReq dropped mid-burst → no IRdValid, IDone or DDone from the spurious ack. The burst still completes all 4 beats.
